// File: rtl/text_screen_dumper_if.sv
// Bus bundle for the screen dumper: start/busy/done control, buffer read port and UART line.
// master = the side that owns the RAM and issues start; slave = the dumper.
interface text_screen_dumper_if #(
  parameter int ROW_W = 2,
  parameter int COL_W = 5
);
  logic             start;
  logic             busy;
  logic             done;
  logic             tx;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic [7:0]       rd_data;

  modport master (
    output start, rd_data,
    input  busy, done, tx, rd_row, rd_col
  );

  modport slave (
    input  start, rd_data,
    output busy, done, tx, rd_row, rd_col
  );
endinterface

// File: rtl/text_screen_dumper.sv
// Streams the ROWSxCOLS character buffer out as 8N1 UART frames, one row per line
// (CR LF after each row), starting each row at column COL_START.
module text_screen_dumper #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int ROWS      = 4,
  parameter int COLS      = 32,
  parameter int COL_START = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  text_screen_dumper_if.slave  bus
);
  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam int CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(BIT_CLKS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_FIRST    = COL_W'(COL_START);
  localparam logic [COL_W-1:0] COL_END      = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] COL_ROW_LAST = COL_W'((COL_START + COLS - 1) % COLS);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SEND, S_DONE} state_t;
  typedef enum logic [1:0] {SYM_CHAR, SYM_CR, SYM_LF} sym_t;

  state_t           state_q, state_d;
  sym_t             sym_q,   sym_d;
  logic [ROW_W-1:0] row_q,   row_d;
  logic [COL_W-1:0] col_q,   col_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       bit_q,   bit_d;
  logic [8:0]       shift_q, shift_d;
  logic             tx_q,    tx_d;
  logic [7:0]       char_byte;

  assign char_byte = (bus.rd_data == 8'h00) ? 8'h20 : bus.rd_data;

  // The address register already points at the next character when FETCH is
  // entered, so FETCH is the RAM latency cycle and LOAD sees valid rd_data.
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        row_d   = '0;
        col_d   = COL_FIRST;
        sym_d   = SYM_CHAR;
        tx_d    = 1'b1;
        state_d = bus.start ? S_FETCH : S_IDLE;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = {1'b1, char_byte};
        tx_d    = 1'b0;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (bit_q != 4'd9) begin
            // Ones shift in behind the data so the stop bit falls out for free.
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
            bit_d   = bit_q + 4'd1;
          end else begin
            case (sym_q)
              SYM_CHAR: begin
                col_d = (col_q == COL_END) ? '0 : col_q + COL_W'(1);
                if (col_q == COL_ROW_LAST) begin
                  sym_d   = SYM_CR;
                  shift_d = {1'b1, 8'h0D};
                  tx_d    = 1'b0;
                  bit_d   = '0;
                end else begin
                  state_d = S_FETCH;
                end
              end
              SYM_CR: begin
                sym_d   = SYM_LF;
                shift_d = {1'b1, 8'h0A};
                tx_d    = 1'b0;
                bit_d   = '0;
              end
              default: begin
                sym_d = SYM_CHAR;
                if (row_q == ROW_LAST) begin
                  row_d   = '0;
                  state_d = S_DONE;
                end else begin
                  row_d   = row_q + ROW_W'(1);
                  state_d = S_FETCH;
                end
              end
            endcase
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sym_q   <= SYM_CHAR;
      row_q   <= '0;
      col_q   <= COL_FIRST;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.tx     = tx_q;
  assign bus.rd_row = row_q;
  assign bus.rd_col = col_q;
  assign bus.done   = (state_q == S_DONE);
  assign bus.busy   = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_SEND);
endmodule
